tx_chan_router: RTL and testbench
=================================

// Module: tx_chan_router
// PURPOSE
//  Routes 32-bit words from the USB packer (usbdata_final/WR_final, txclk domain) to per-channel packet RAMs.
//  Decodes the channel field of each packet's first word and forwards all 128 words of the packet to one RAM.
//  Pulses that RAM's WR_done after the last word.
//  Drops packets whose channel is unknown or whose RAM lacks space, and counts the drops.
//  Sits between tx_packer and the data/command channel_ram instances inside the inband TX buffer.
// PARAMETERS
//  NUM_CHAN   2      number of data channels; command RAM is index NUM_CHAN
//  PKT_WORDS  128    32-bit words per USB packet (512 bytes), header included
//  CMD_CHAN   5'h1F  header channel code selecting the command RAM
// PORTS
//  txclk            in   1           clock; all logic rising-edge
//  reset_n          in   1           asynchronous, active-low reset
//  usbdata_final    in   32          packed word from tx_packer
//  WR_final         in   1           one-cycle strobe: usbdata_final valid
//  chan_have_space  in   NUM_CHAN+1  per-RAM space for one whole packet
//  ram_data         out  32          registered copy of the accepted word, shared by all RAMs
//  WR_channel       out  NUM_CHAN+1  one-hot write strobe, aligned with ram_data
//  WR_done_channel  out  NUM_CHAN+1  one-hot end-of-packet pulse
//  drop_count       out  16          saturating count of dropped packets
//  route_state      out  2           FSM state, for the debug bus
// BEHAVIOUR
//  Reset values: all outputs 0, FSM=IDLE, word counter=0, selected index=0. Reset is async at any point.
//    A reset mid-packet discards the partial packet and issues no WR_done.
//  Header fields of word 0: chan = [20:16]; all other bits are passed through untouched.
//  Decode: chan<NUM_CHAN -> idx=chan; chan==CMD_CHAN -> idx=NUM_CHAN; anything else is invalid.
//  FSM (route_state encoding 0/1/2):
//   IDLE:  on WR_final, the word is the header.
//          Valid chan with chan_have_space[idx]=1: latch idx, write the header, counter=1, go to ROUTE.
//          Otherwise: counter=1, drop_count+1 (saturates at 16'hFFFF), go to DROP.
//   ROUTE: each WR_final writes to the latched idx and increments the counter.
//          The word with counter==PKT_WORDS-1 is the last: counter=0, go to IDLE.
//   DROP:  identical word counting, no writes. On the last word: counter=0, go to IDLE.
//  Latency: the word accepted at edge N appears on ram_data, with WR_channel[idx]=1 for one cycle, after edge N+1.
//    WR_done_channel[idx]=1 for one cycle after edge N+2 for the last word.
//    ram_data holds its value when there is no write.
//  Space is sampled only at the header. A later drop of chan_have_space never truncates the packet.
//  Back-to-back packets: a header may arrive the cycle after the last word (FSM is already in IDLE).
//    WR_done of packet k may then coincide with WR_channel for packet k+1's header, on the same or a different index.
//    Both are legal and independent.
//  WR_final is ignored on a cycle where it is not asserted. A gap of any length between words is legal.
//  Counter width is clog2(PKT_WORDS). PKT_WORDS is a power of two; wrap is explicit at PKT_WORDS-1.
//  At most one bit of WR_channel is set, and at most one bit of WR_done_channel is set.
// STRUCTURE
//  Shared include tx_inband_defs.vh, holding:
//   - header field positions (CHAN_HI=20, CHAN_LO=16)
//   - CMD_CHAN and PKT_WORDS
//   - FSM state localparams ST_IDLE/ST_ROUTE/ST_DROP
//  One sub-module: tx_route_decode (combinational) takes chan, NUM_CHAN and chan_have_space.
//    It outputs idx, valid and accept.
//  The FSM, word counter, output registers, done pipeline and drop counter stay in tx_chan_router.
// TESTING
//  1. Header chan=0 plus 127 words 32'h0000_0001..7F, space=all 1.
//     -> 128 WR_channel[0] pulses carrying those words in order; one WR_done_channel[0] two cycles after the last WR_final.
//  2. Header chan=5'h1F, NUM_CHAN=2.
//     -> all writes on WR_channel[2], WR_done_channel[2] once; bits [1:0] stay 0.
//  3. Header chan=5'h05 (invalid), then a header chan=1 packet.
//     -> first 128 words produce no strobes, drop_count=1; second packet routed to index 1.
//  4. chan=1 with chan_have_space[1]=0 at the header, raised on word 3.
//     -> whole packet dropped, drop_count increments; the next packet (space=1) is routed normally.
//  5. Two chan=0/chan=1 packets back-to-back with WR_final held high for 256 cycles.
//     -> WR_done_channel[0] coincides with the second packet's WR_channel[1]; 128 writes each.
//  6. Deassert reset_n after word 60 of a chan=0 packet, then send a full chan=0 packet.
//     -> outputs 0 immediately, no WR_done for the aborted packet; new packet routed with the counter restarting from the header.

Source files
------------

// File: rtl/tx_chan_router_pkg.sv
// Shared constants, header layout and FSM state encoding for the inband TX channel router.
package tx_chan_router_pkg;

  localparam int         NUM_CHAN_DEF = 2;
  localparam int         PKT_WORDS    = 128;
  localparam logic [4:0] CMD_CHAN     = 5'h1F;
  localparam int         CHAN_HI      = 20;
  localparam int         CHAN_LO      = 16;
  localparam int         CNT_W        = $clog2(PKT_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUTE = 2'd1,
    ST_DROP  = 2'd2
  } route_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

endpackage

// File: rtl/tx_route_decode.sv
// Header channel decode: maps the 5-bit channel code to a RAM index and
// reports whether the code is known and whether that RAM has room.
module tx_route_decode
  import tx_chan_router_pkg::*;
#(
  parameter int NUM_CHAN = NUM_CHAN_DEF,
  parameter int IDX_W    = $clog2(NUM_CHAN + 1)
) (
  input  logic [4:0]       chan_i,
  input  logic [NUM_CHAN:0] have_space_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o,
  output logic             accept_o
);

  // Channel code to RAM index, command code lands on the last RAM
  always_comb begin
    idx_o    = '0;
    valid_o  = 1'b0;
    accept_o = 1'b0;
    if (32'(chan_i) < NUM_CHAN) begin
      idx_o   = IDX_W'(chan_i);
      valid_o = 1'b1;
    end else if (chan_i == CMD_CHAN) begin
      idx_o   = IDX_W'(NUM_CHAN);
      valid_o = 1'b1;
    end else begin
      valid_o = 1'b0;
    end
    accept_o = valid_o & have_space_i[idx_o];
  end

endmodule

// File: rtl/tx_chan_router.sv
// Routes each 128-word USB packet from tx_packer to one channel RAM chosen by
// the header, pulses that RAM's done after the last word, and counts drops.
module tx_chan_router
  import tx_chan_router_pkg::*;
#(
  parameter int NUM_CHAN = NUM_CHAN_DEF
) (
  input  logic              txclk,
  input  logic              reset_n,
  input  logic [31:0]       usbdata_final,
  input  logic              WR_final,
  input  logic [NUM_CHAN:0] chan_have_space,
  output logic [31:0]       ram_data,
  output logic [NUM_CHAN:0] WR_channel,
  output logic [NUM_CHAN:0] WR_done_channel,
  output logic [15:0]       drop_count,
  output logic [1:0]        route_state
);

  localparam int IDX_W = $clog2(NUM_CHAN + 1);

  route_state_e      state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [IDX_W-1:0]  idx_q;
  logic [31:0]       data_q;
  logic [NUM_CHAN:0] wr_q;
  logic              last_q;
  logic [NUM_CHAN:0] done_q;
  logic [15:0]       drops_q;

  logic [IDX_W-1:0]  dec_idx_s;
  logic              dec_valid_s;
  logic              dec_accept_s;
  logic              cnt_last_s;

  tx_route_decode #(
    .NUM_CHAN (NUM_CHAN),
    .IDX_W    (IDX_W)
  ) u_decode (
    .chan_i       (usbdata_final[CHAN_HI:CHAN_LO]),
    .have_space_i (chan_have_space),
    .idx_o        (dec_idx_s),
    .valid_o      (dec_valid_s),
    .accept_o     (dec_accept_s)
  );

  function automatic logic [NUM_CHAN:0] onehot(input logic [IDX_W-1:0] i);
    logic [NUM_CHAN:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  assign cnt_last_s = (cnt_q == CNT_W'(PKT_WORDS - 1));

  // Packet FSM, word counter, write/done pipeline and drop counter
  always_ff @(posedge txclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= 32'd0;
      wr_q    <= '0;
      last_q  <= 1'b0;
      done_q  <= '0;
      drops_q <= 16'd0;
    end else begin
      wr_q   <= '0;
      last_q <= 1'b0;
      // Done trails the final write strobe by one cycle on the same RAM
      done_q <= last_q ? wr_q : '0;
      if (WR_final) begin
        case (state_q)
          ST_IDLE: begin
            cnt_q <= CNT_W'(1);
            if (dec_accept_s) begin
              idx_q   <= dec_idx_s;
              data_q  <= usbdata_final;
              wr_q    <= onehot(dec_idx_s);
              state_q <= ST_ROUTE;
            end else begin
              drops_q <= sat_inc16(drops_q);
              state_q <= ST_DROP;
            end
          end
          ST_ROUTE: begin
            data_q <= usbdata_final;
            wr_q   <= onehot(idx_q);
            if (cnt_last_s) begin
              cnt_q   <= '0;
              last_q  <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          ST_DROP: begin
            if (cnt_last_s) begin
              cnt_q   <= '0;
              state_q <= ST_IDLE;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          default: begin
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign ram_data        = data_q;
  assign WR_channel      = wr_q;
  assign WR_done_channel = done_q;
  assign drop_count      = drops_q;
  assign route_state     = state_q;

  logic unused_s;
  assign unused_s = dec_valid_s;

endmodule

// File: tb/tb_tx_chan_router.sv
// Randomized scoreboard bench for tx_chan_router: the driver predicts writes and
// done pulses from the packet rules, a negedge monitor pops and compares them.
module tb_tx_chan_router;

  logic        txclk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] usbdata_final = 32'd0;
  logic        WR_final = 1'b0;
  logic [2:0]  chan_have_space = 3'b000;
  logic [31:0] ram_data;
  logic [2:0]  WR_channel;
  logic [2:0]  WR_done_channel;
  logic [15:0] drop_count;
  logic [1:0]  route_state;

  tx_chan_router #(.NUM_CHAN(2)) dut (
    .txclk           (txclk),
    .reset_n         (reset_n),
    .usbdata_final   (usbdata_final),
    .WR_final        (WR_final),
    .chan_have_space (chan_have_space),
    .ram_data        (ram_data),
    .WR_channel      (WR_channel),
    .WR_done_channel (WR_done_channel),
    .drop_count      (drop_count),
    .route_state     (route_state)
  );

  always #5 txclk = ~txclk;

  int cyc = 0;
  always @(posedge txclk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [2:0]  oh;
    logic [31:0] data;
  } exp_t;

  exp_t wr_exp[$];
  exp_t done_exp[$];
  exp_t mon_e;
  exp_t mon_d;
  logic [31:0] last_data = 32'd0;

  int n_cmp  = 0;
  int n_fail = 0;
  int drop_exp = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endfunction

  // Reference target: data channels 0..1, command code 31 -> RAM 2, else none
  function automatic int ref_target(logic [4:0] ch);
    if (ch < 5'd2) return int'(ch);
    else if (ch == 5'h1F) return 2;
    else return -1;
  endfunction

  task automatic send_pkt(input logic [4:0] ch, input logic [2:0] sp_hdr,
                          input logic [2:0] sp_late, input int nwords,
                          input int maxgap, input bit seq);
    int          tgt;
    bit          route;
    int          g;
    logic [31:0] w;
    tgt   = ref_target(ch);
    route = 1'b0;
    if (tgt >= 0) route = sp_hdr[tgt];
    if (!route && drop_exp < 65535) drop_exp++;
    for (int i = 0; i < nwords; i++) begin
      @(posedge txclk); #1;
      w = seq ? 32'(i) : $urandom;
      if (i == 0) w[20:16] = ch;
      chan_have_space = (i < 3) ? sp_hdr : sp_late;
      usbdata_final   = w;
      WR_final        = 1'b1;
      if (route) begin
        wr_exp.push_back('{cyc + 1, 3'(1 << tgt), w});
        if (i == 127) done_exp.push_back('{cyc + 2, 3'(1 << tgt), 32'd0});
      end
      if (i == 1) begin
        @(negedge txclk);
        chk("route_state_mid", 64'(route_state), route ? 64'd1 : 64'd2);
      end
      g = (maxgap > 0) ? $urandom_range(maxgap, 0) : 0;
      repeat (g) begin
        @(posedge txclk); #1;
        WR_final = 1'b0;
      end
    end
  endtask

  task automatic idle_check(input int n);
    @(posedge txclk); #1;
    WR_final = 1'b0;
    repeat (n) @(posedge txclk);
    @(negedge txclk);
    chk("drop_count", 64'(drop_count), 64'(drop_exp));
    chk("route_state_idle", 64'(route_state), 64'd0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ram_data"}, 64'(ram_data), 64'd0);
    chk({tag, "_wr"}, 64'(WR_channel), 64'd0);
    chk({tag, "_done"}, 64'(WR_done_channel), 64'd0);
    chk({tag, "_drops"}, 64'(drop_count), 64'd0);
    chk({tag, "_state"}, 64'(route_state), 64'd0);
  endtask

  // Scoreboard monitor: pops expectations whenever a strobe appears or is due
  always @(negedge txclk) begin
    if (!reset_n) begin
      last_data <= 32'd0;
    end else begin
      if (WR_channel != 3'b000) begin
        if (wr_exp.size() == 0) begin
          chk("wr_unexpected", 64'(WR_channel), 64'd0);
        end else begin
          mon_e = wr_exp.pop_front();
          chk("wr_chan", 64'(WR_channel), 64'(mon_e.oh));
          chk("wr_data", 64'(ram_data), 64'(mon_e.data));
          chk("wr_cycle", 64'(cyc), 64'(mon_e.cyc));
          last_data <= mon_e.data;
        end
      end else begin
        chk("ram_data_hold", 64'(ram_data), 64'(last_data));
        if (wr_exp.size() > 0 && wr_exp[0].cyc <= cyc) begin
          mon_e = wr_exp.pop_front();
          chk("wr_missing", 64'(WR_channel), 64'(mon_e.oh));
        end
      end
      if (WR_done_channel != 3'b000) begin
        if (done_exp.size() == 0) begin
          chk("done_unexpected", 64'(WR_done_channel), 64'd0);
        end else begin
          mon_d = done_exp.pop_front();
          chk("done_chan", 64'(WR_done_channel), 64'(mon_d.oh));
          chk("done_cycle", 64'(cyc), 64'(mon_d.cyc));
        end
      end else if (done_exp.size() > 0 && done_exp[0].cyc <= cyc) begin
        mon_d = done_exp.pop_front();
        chk("done_missing", 64'(WR_done_channel), 64'(mon_d.oh));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0] rch;
    reset_n = 1'b0;
    repeat (3) @(posedge txclk);
    @(negedge txclk);
    check_zero("reset");
    @(posedge txclk); #1;
    reset_n = 1'b1;
    @(negedge txclk);
    check_zero("post_reset");

    // Sequential payload to RAM 0, no gaps
    send_pkt(5'd0, 3'b111, 3'b111, 128, 0, 1'b1);
    idle_check(3);
    // Command channel with gaps
    send_pkt(5'h1F, 3'b111, 3'b111, 128, 2, 1'b0);
    idle_check(3);
    // Unknown channel dropped, then RAM 1
    send_pkt(5'h05, 3'b111, 3'b111, 128, 1, 1'b0);
    idle_check(3);
    send_pkt(5'd1, 3'b111, 3'b111, 128, 1, 1'b0);
    idle_check(3);
    // No space at header, raised on word 3: still dropped
    send_pkt(5'd1, 3'b101, 3'b111, 128, 1, 1'b0);
    idle_check(3);
    send_pkt(5'd1, 3'b111, 3'b111, 128, 0, 1'b0);
    idle_check(3);
    // Back-to-back RAM 0 then RAM 1 with WR_final held high
    send_pkt(5'd0, 3'b111, 3'b111, 128, 0, 1'b0);
    send_pkt(5'd1, 3'b111, 3'b111, 128, 0, 1'b0);
    idle_check(3);

    // Reset mid-packet after word 60
    send_pkt(5'd0, 3'b111, 3'b111, 61, 0, 1'b0);
    @(posedge txclk); #1;
    WR_final = 1'b0;
    repeat (2) @(posedge txclk);
    #1;
    reset_n  = 1'b0;
    drop_exp = 0;
    #1;
    check_zero("mid_reset");
    @(posedge txclk); #1;
    reset_n = 1'b1;
    send_pkt(5'd0, 3'b111, 3'b111, 128, 1, 1'b0);
    idle_check(3);

    // Random packets
    for (int k = 0; k < 8; k++) begin
      case ($urandom_range(3, 0))
        0: rch = 5'd0;
        1: rch = 5'd1;
        2: rch = 5'h1F;
        default: rch = 5'($urandom);
      endcase
      send_pkt(rch, 3'($urandom), 3'($urandom), 128, $urandom_range(3, 0), 1'b0);
    end
    idle_check(3);

    for (int i = 0; i < 50 && (wr_exp.size() > 0 || done_exp.size() > 0); i++)
      @(posedge txclk);
    @(negedge txclk);
    chk("wr_queue_empty", 64'(wr_exp.size()), 64'd0);
    chk("done_queue_empty", 64'(done_exp.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
